// File: rtl/cpu4_mc_pkg.sv
// Shared encodings for the cpu4 multicycle control unit: FSM states,
// opcodes and the datapath select encodings.
package cpu4_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that wait MEM_LAT enabled cycles on the shared memory.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/cpu4_mc_outdec.sv
// Moore control-word decode from (state, last memory cycle, en).
// Optional addi states are decoded only when CPU4_MC_ADDI_EN is defined.
module cpu4_mc_outdec
  import cpu4_mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       last,
  input  logic       en,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop
);

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = last;
        pcwrite = last;
      end
      S_DECODE:  alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = last;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = PCSRC_ALUOUT;
      end
`ifdef CPU4_MC_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB:  regwrite = 1'b1;
`endif
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // A stalled cycle must not commit anything; selects keep their decode.
    if (!en) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      branch   = 1'b0;
    end
  end

endmodule

// File: rtl/cpu4_mc_ctrl.sv
// Multicycle main control FSM for cpu4 with parametrised memory latency and stall.
// Define CPU4_MC_ADDI_EN to support addi; otherwise opcode 001000 is illegal.
module cpu4_mc_ctrl
  import cpu4_mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_state;
  logic             last;
  logic             legal;

  assign mem_state = is_mem_state(state_q);
  assign last      = mem_state && (cnt_q == LAST_CNT);
  assign cnt_d     = (mem_state && !last) ? cnt_q + 1'b1 : '0;

  // Reset mid-access drops the pending strobe simply by returning to FETCH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    legal   = 1'b1;
    case (state_q)
      S_FETCH:  state_d = last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
`ifdef CPU4_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          OP_J:         state_d = S_JEX;
          default:      legal   = 1'b0;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = last ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = last ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef CPU4_MC_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  cpu4_mc_outdec u_outdec (
    .state    (state_q),
    .last     (last),
    .en       (en),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop)
  );

  assign pcen       = pcwrite | (branch & zero);
  assign illegal_op = en && (state_q == S_DECODE) && !legal;
  assign state      = state_q;

endmodule

// File: doc/cpu4_mc_ctrl.md
Name: cpu4_mc_ctrl

Overview:
Multicycle main control unit for the cpu4 MIPS core. It supersedes the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. Memory latency is parametrised, and a core-level stall input is provided. It drives the shared-memory multicycle datapath; the ALU function decoder stays a separate block fed by aluop.

Parameters:
MEM_LAT, 1, cycles per memory access state (FETCH, MEMRD, MEMWR); legal range 1..15
CNT_W, 4, width of the memory-latency counter; must satisfy MEM_LAT <= 2^CNT_W-1

Ports:
clk  in  1  core clock, rising edge
resetn  in  1  asynchronous active-low reset
en  in  1  advance enable; 0 = stall
op  in  6  instruction opcode from the instruction register
zero  in  1  ALU zero flag
iord  out  1  memory address select: 1 = ALUOut, 0 = PC
memwrite  out  1  data memory write strobe
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC write
branch  out  1  branch qualifier
pcen  out  1  pcwrite | (branch & zero)
regdst  out  1  rd (1) / rt (0) destination select
memtoreg  out  1  writeback data from memory
regwrite  out  1  register file write
alusrca  out  1  ALU A select: 0 = PC, 1 = rs
alusrcb  out  2  ALU B select: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
aluop  out  2  00 add, 01 sub, 10 funct-decoded
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
state  out  4  current state (debug)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, resetn).
- Reset: state=FETCH (0) and counter=0. All outputs are a Moore decode of state (and counter where noted), so outputs after reset are the FETCH decode.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12-15 are unreachable and return to FETCH.
- Transitions (only on cycles with en=1):
  - FETCH→DECODE
  - DECODE: lw/sw (100011/101011)→MEMADR; R-type (000000)→RTYPEEX; beq (000100)→BEQEX; addi (001000)→ADDIEX; j (000010)→JEX; any other opcode→FETCH with illegal_op=1
  - MEMADR: lw→MEMRD, sw→MEMWR
  - MEMRD→MEMWB
  - RTYPEEX→RTYPEWB
  - ADDIEX→ADDIWB
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX→FETCH
- Memory latency:
  - FETCH, MEMRD and MEMWR each last MEM_LAT enabled cycles.
  - The counter increments each enabled cycle in these states. The state exits when counter==MEM_LAT-1, and the counter clears on exit.
  - irwrite and pcwrite (FETCH) and memwrite (MEMWR) assert only on the final cycle. iord and the select outputs hold for the whole window.
- Control decode, per state (unlisted outputs are 0):
  - FETCH: alusrcb=01, aluop=00, pcsrc=00, plus irwrite and pcwrite on the final cycle
  - DECODE: alusrcb=11
  - MEMADR: alusrca=1, alusrcb=10
  - MEMRD: iord=1
  - MEMWB: regwrite=1, memtoreg=1
  - MEMWR: iord=1, plus memwrite on the final cycle
  - RTYPEEX: alusrca=1, aluop=10
  - RTYPEWB: regdst=1, regwrite=1
  - BEQEX: alusrca=1, aluop=01, branch=1, pcsrc=01
  - ADDIEX: alusrca=1, alusrcb=10
  - ADDIWB: regwrite=1
  - JEX: pcsrc=10, pcwrite=1
- Stall (en=0): state and counter hold. irwrite, pcwrite, memwrite, regwrite, branch and illegal_op are forced to 0. Selects keep their state decode.
- op is sampled only in DECODE and MEMADR. It must be stable while the IR is not being written.
- An async reset mid-access aborts the access: no write strobe is produced and the FSM restarts at FETCH.

Optional Feature:
CPU4_MC_ADDI_EN:
- Defined: addi is supported through ADDIEX and ADDIWB as above.
- Undefined: opcode 001000 is illegal (DECODE→FETCH, illegal_op pulses). States 9 and 10 are treated as unreachable and return to FETCH.

Decomposition:
- Package cpu4_mc_pkg holds the state encodings, opcode constants, and the alusrcb, pcsrc and aluop encodings.
- Sub-module cpu4_mc_outdec: purely combinational decode from (state, last-cycle flag, en) to the control word.
- The FSM and counter stay in cpu4_mc_ctrl.

Test Plan:
- MEM_LAT=1, op=100011 (lw), en=1: state sequence 0,1,2,3,4,0. irwrite and pcwrite high in cycle 0; memtoreg and regwrite high in state 4.
- MEM_LAT=3, op=101011 (sw): FETCH lasts 3 cycles with irwrite high only on the 3rd. MEMWR lasts 3 cycles with memwrite high only on the 3rd.
- op=000100 (beq), zero=1: in BEQEX, pcen=1, pcsrc=01, aluop=01. With zero=0 in BEQEX: pcen=0.
- op=111111 in DECODE: illegal_op pulses for exactly one cycle; next state is FETCH; no regwrite or memwrite.
- en held 0 for 4 cycles mid-RTYPEEX: state stays 6 and regwrite stays 0. Then RTYPEWB produces a single regwrite with regdst=1.
- resetn asserted low during the 2nd MEMWR cycle (MEM_LAT=3): state becomes 0 immediately, memwrite never asserts, and the next fetch proceeds normally.
